vga_frame_reader: RTL
=====================

Name: vga_frame_reader

Overview:
- Clocked, parametrised successor to the combinational VGA address generator.
- Walks the VGA raster (x, y) and issues read addresses into the shared image RAM for either the original image or the interpolated quadrant, with integer zoom (pixel replication ×1/×2/×4).
- Fetches the image dimension word during vertical blanking and latches all frame parameters at frame start, so they stay stable for the whole frame.
- Sits between the VGA timing generator and the image RAM read port. Feeds the colour mux with a pixel-valid flag aligned to returned data.

Parameters:
- ADDR_W, 19, RAM address width.
- DIM_W, 16, dimension word width.
- H_START, 145, first visible x column.
- V_START, 35, first visible y line.
- DIM_ADDR, 19'h2, RAM address of the dimension word.
- ORIG_BASE, 19'h5, base address of the original image.
- INTERP_BASE, 19'h3D289, base address of the interpolated quadrant.
- MAX_DIM, 400, clamp for the effective displayed size (after zoom).
- RD_LAT, 1, RAM read latency in pixel ticks (1..3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_tick  in  1  pixel-rate enable; all state advances only when this is 1.
- x  in  10  VGA column counter.
- y  in  10  VGA line counter.
- interpolacion  in  1  mode select: 0 = original image, 1 = quadrant.
- zoom  in  2  replication exponent: 0 = ×1, 1 = ×2, 2 = ×4; 3 is treated as 2.
- dim_in  in  DIM_W  RAM read data, used during the dimension fetch.
- rd_addr  out  ADDR_W  RAM read address.
- rd_en  out  1  read strobe.
- pixel_valid  out  1  data at the RAM output is an image pixel (delayed RD_LAT ticks).
- frame_start  out  1  one-tick pulse when frame parameters are latched.

Behaviour:
- Reset values:
  - rd_addr = DIM_ADDR; all other outputs 0.
  - State = FETCH; dim_reg = 0; w_eff = 0.
- Reset asserted mid-frame: outputs return to reset values immediately. On release, no pixels are shown until a full FETCH has completed.
- FSM states: FETCH, WAIT, ARMED, ACTIVE.
- FETCH:
  - Entered whenever y < V_START.
  - rd_addr = DIM_ADDR, rd_en = 1.
  - After RD_LAT ticks, capture dim_in into dim_reg and go to WAIT.
- WAIT:
  - rd_en = 0.
  - On the first tick with y == V_START:
    - Latch mode_r = interpolacion and z = min(zoom, 2).
    - Compute w_src:
      - mode 0: w_src = dim_reg.
      - mode 1: w_src = (dim_reg >> 2) * 3 − 2; saturate to 0 if dim_reg < 4.
    - w_eff = min(w_src << z, MAX_DIM); all arithmetic in DIM_W+2 bits before clamping.
    - row_base = mode_r ? INTERP_BASE : ORIG_BASE.
    - Clear row_rep and line counters.
    - Pulse frame_start, go to ACTIVE.
- ACTIVE, visible-window test per tick: win = (x ≥ H_START) && (x < H_START + w_eff) && (y ≥ V_START) && (y < V_START + w_eff).
- ACTIVE, when win:
  - rd_en = 1, rd_addr = row_base + (col >> z); col increments each tick.
  - On the last column of the line, col clears.
  - The line counter increments on the last column. Every 2^z lines, row_base += w_src (source row advance).
  - Earlier lines of a zoom group re-read the same source row.
- ACTIVE, when !win: rd_en = 0, rd_addr holds its last value.
- Exiting ACTIVE: y < V_START (next frame) returns to FETCH. The interpolacion and zoom inputs are ignored mid-frame.
- w_eff == 0: ACTIVE never asserts rd_en; the frame is blank.
- pixel_valid: rd_en && in ACTIVE, delayed through an RD_LAT-stage shift register advanced by pix_tick. Its latency equals the RAM latency exactly.
- rd_addr is registered, one tick after (x, y) are sampled; the VGA timing generator compensates.
- Address wrap: row_base + col is computed modulo 2^ADDR_W with no saturation. Software guarantees images fit in RAM.
- pix_tick = 0: all registers hold; frame_start cannot pulse.

Decomposition:
- Package vga_pkg:
  - State enum typedef (FETCH, WAIT, ARMED, ACTIVE; ARMED is reserved and maps to WAIT behaviour).
  - Address/dimension constants: DIM_ADDR, ORIG_BASE, INTERP_BASE, H_START, V_START.
  - A function computing w_src from (dim, mode).
- One sub-module: vga_valid_pipe, a parametrised RD_LAT-deep enable-gated delay line for pixel_valid.

Test Plan:
- dim_in = 392, mode 0, zoom 0:
  - First visible tick: rd_addr = 0x5.
  - End of line 0: rd_addr = 0x5 + 391.
  - Line 1 start: rd_addr = 0x5 + 392.
  - frame_start pulses once per frame.
- dim_in = 392, mode 1: w_src = 292. First address = 0x3D289; line 1 starts at 0x3D289 + 292; window x ∈ [145, 437).
- dim_in = 100, zoom = 1:
  - w_eff = 200; each address repeats for 2 ticks.
  - Lines 0 and 1 both start at 0x5; line 2 starts at 0x5 + 100.
- dim_in = 300, zoom = 2: w_eff clamps to 400. dim_in = 3, mode 1: w_src = 0, so there is no rd_en for the whole frame.
- Toggle interpolacion mid-frame: addresses for the current frame are unchanged; the new mode applies after the next frame_start.
- RD_LAT = 2 with random pix_tick gaps: pixel_valid equals rd_en delayed exactly 2 ticks. Assert rst_n low mid-line: outputs go to reset values immediately, and no rd_en occurs until the next FETCH completes.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame reader: FSM states, RAM map
// and the source-width calculation used when frame parameters are latched.
package vga_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        ARMED  = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    localparam logic [18:0] DIM_ADDR    = 19'h2;
    localparam logic [18:0] ORIG_BASE   = 19'h5;
    localparam logic [18:0] INTERP_BASE = 19'h3D289;
    localparam int unsigned H_START     = 145;
    localparam int unsigned V_START     = 35;

    // Quadrant rows hold 3/4 of the source width minus the two border pixels.
    function automatic logic [31:0] calc_w_src(input logic [31:0] dim, input logic mode);
        if (!mode) begin
            return dim;
        end
        if (dim < 32'd4) begin
            return '0;
        end
        return (dim >> 2) * 32'd3 - 32'd2;
    endfunction

endpackage

// File: rtl/vga_valid_pipe.sv
// Enable-gated delay line that keeps pixel_valid aligned with RAM read data.
module vga_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_frame_reader.sv
// Raster-driven image RAM reader: fetches the dimension word in blanking,
// latches frame parameters at frame start and issues zoomed pixel reads.
module vga_frame_reader #(
    parameter int                 ADDR_W      = 19,
    parameter int                 DIM_W       = 16,
    parameter int unsigned        H_START     = vga_pkg::H_START,
    parameter int unsigned        V_START     = vga_pkg::V_START,
    parameter logic [ADDR_W-1:0]  DIM_ADDR    = ADDR_W'(vga_pkg::DIM_ADDR),
    parameter logic [ADDR_W-1:0]  ORIG_BASE   = ADDR_W'(vga_pkg::ORIG_BASE),
    parameter logic [ADDR_W-1:0]  INTERP_BASE = ADDR_W'(vga_pkg::INTERP_BASE),
    parameter int unsigned        MAX_DIM     = 400,
    parameter int                 RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_tick,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              interpolacion,
    input  logic [1:0]        zoom,
    input  logic [DIM_W-1:0]  dim_in,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              pixel_valid,
    output logic              frame_start
);

    import vga_pkg::*;

    localparam int WW = DIM_W + 2;

    state_t            state_q, state_n;
    logic [1:0]        fetch_cnt_q, fetch_cnt_n;
    logic [DIM_W-1:0]  dim_reg_q, dim_reg_n;
    logic [1:0]        z_q, z_n;
    logic [WW-1:0]     w_src_q, w_src_n;
    logic [WW-1:0]     w_eff_q, w_eff_n;
    logic [WW-1:0]     col_q, col_n;
    logic [1:0]        rep_q, rep_n;
    logic [ADDR_W-1:0] row_base_q, row_base_n;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
    logic              rd_en_q, rd_en_n;
    logic              pix_rd_q, pix_rd_n;
    logic              fs_q, fs_n;

    logic [WW-1:0]     x_w, y_w, ws_calc, ws_shift;
    logic [1:0]        z_in, rep_max;
    logic              win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            fetch_cnt_q <= '0;
            dim_reg_q   <= '0;
            z_q         <= '0;
            w_src_q     <= '0;
            w_eff_q     <= '0;
            col_q       <= '0;
            rep_q       <= '0;
            row_base_q  <= '0;
            rd_addr_q   <= DIM_ADDR;
            rd_en_q     <= 1'b0;
            pix_rd_q    <= 1'b0;
            fs_q        <= 1'b0;
        end else if (pix_tick) begin
            state_q     <= state_n;
            fetch_cnt_q <= fetch_cnt_n;
            dim_reg_q   <= dim_reg_n;
            z_q         <= z_n;
            w_src_q     <= w_src_n;
            w_eff_q     <= w_eff_n;
            col_q       <= col_n;
            rep_q       <= rep_n;
            row_base_q  <= row_base_n;
            rd_addr_q   <= rd_addr_n;
            rd_en_q     <= rd_en_n;
            pix_rd_q    <= pix_rd_n;
            fs_q        <= fs_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        fetch_cnt_n = fetch_cnt_q;
        dim_reg_n   = dim_reg_q;
        z_n         = z_q;
        w_src_n     = w_src_q;
        w_eff_n     = w_eff_q;
        col_n       = col_q;
        rep_n       = rep_q;
        row_base_n  = row_base_q;
        rd_addr_n   = rd_addr_q;
        rd_en_n     = 1'b0;
        pix_rd_n    = 1'b0;
        fs_n        = 1'b0;

        x_w      = WW'(x);
        y_w      = WW'(y);
        z_in     = (zoom == 2'd3) ? 2'd2 : zoom;
        ws_calc  = WW'(calc_w_src(32'(dim_reg_q), interpolacion));
        ws_shift = ws_calc << z_in;
        win      = (x_w >= WW'(H_START)) && (x_w < WW'(H_START) + w_eff_q) &&
                   (y_w >= WW'(V_START)) && (y_w < WW'(V_START) + w_eff_q);
        case (z_q)
            2'd0:    rep_max = 2'd0;
            2'd1:    rep_max = 2'd1;
            default: rep_max = 2'd3;
        endcase

        case (state_q)
            // The dimension address is held until the RAM has had RD_LAT ticks to answer.
            FETCH: begin
                rd_addr_n = DIM_ADDR;
                if (fetch_cnt_q == 2'(RD_LAT)) begin
                    dim_reg_n   = dim_in;
                    fetch_cnt_n = '0;
                    state_n     = WAIT;
                end else begin
                    rd_en_n     = 1'b1;
                    fetch_cnt_n = fetch_cnt_q + 2'd1;
                end
            end
            WAIT, ARMED: begin
                if (y_w == WW'(V_START)) begin
                    z_n        = z_in;
                    w_src_n    = ws_calc;
                    w_eff_n    = (ws_shift > WW'(MAX_DIM)) ? WW'(MAX_DIM) : ws_shift;
                    row_base_n = interpolacion ? INTERP_BASE : ORIG_BASE;
                    col_n      = '0;
                    rep_n      = '0;
                    fs_n       = 1'b1;
                    state_n    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (y_w < WW'(V_START)) begin
                    rd_en_n     = 1'b1;
                    rd_addr_n   = DIM_ADDR;
                    fetch_cnt_n = '0;
                    state_n     = FETCH;
                end else if (win) begin
                    rd_en_n   = 1'b1;
                    pix_rd_n  = 1'b1;
                    rd_addr_n = row_base_q + ADDR_W'(col_q >> z_q);
                    // A zoom group re-reads one source row; advance only after its last line.
                    if (col_q == w_eff_q - WW'(1)) begin
                        col_n = '0;
                        if (rep_q == rep_max) begin
                            rep_n      = '0;
                            row_base_n = row_base_q + ADDR_W'(w_src_q);
                        end else begin
                            rep_n = rep_q + 2'd1;
                        end
                    end else begin
                        col_n = col_q + WW'(1);
                    end
                end
            end
            default: state_n = FETCH;
        endcase
    end

    vga_valid_pipe #(.DEPTH(RD_LAT)) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_tick),
        .d     (pix_rd_q),
        .q     (pixel_valid)
    );

    assign rd_addr     = rd_addr_q;
    assign rd_en       = rd_en_q;
    assign frame_start = fs_q;

endmodule
